// File: rtl/router_dest_reader.sv
// Destination-side reader for one router output port: drains one packet per
// vld_out episode from the output FIFO, checks its parity and keeps counts.
module router_dest_reader #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned START_DLY = 0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              vld_out,
    input  logic [DATA_W-1:0] data_out,
    input  logic              soft_reset,
    input  logic              rd_stall,
    output logic              read_enb,
    output logic              busy,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic              pkt_abort,
    output logic [5:0]        pkt_len,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        HDR_REQ,
        HDR_CAP,
        BODY,
        DONE
    } state_t;

    localparam logic [4:0] DLY_LAST = (START_DLY > 0) ? 5'(START_DLY - 1) : 5'd0;

    state_t             state_q, state_d;
    logic [4:0]         dly_q, dly_d;
    logic [6:0]         req_left_q, req_left_d;
    logic [6:0]         cap_left_q, cap_left_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic               rd_q, rd_d;
    logic [5:0]         pkt_len_q, pkt_len_d;
    logic               pkt_err_q, pkt_err_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= IDLE;
            dly_q      <= '0;
            req_left_q <= '0;
            cap_left_q <= '0;
            acc_q      <= '0;
            rd_q       <= 1'b0;
            pkt_len_q  <= '0;
            pkt_err_q  <= 1'b0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            req_left_q <= req_left_d;
            cap_left_q <= cap_left_d;
            acc_q      <= acc_d;
            rd_q       <= rd_d;
            pkt_len_q  <= pkt_len_d;
            pkt_err_q  <= pkt_err_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        req_left_d = req_left_q;
        cap_left_d = cap_left_q;
        acc_d      = acc_q;
        rd_d       = 1'b0;
        pkt_len_d  = pkt_len_q;
        pkt_err_d  = pkt_err_q;
        pkt_cnt_d  = pkt_cnt_q;
        err_cnt_d  = err_cnt_q;
        read_enb   = 1'b0;
        pkt_done   = 1'b0;
        pkt_abort  = 1'b0;

        unique case (state_q)
            IDLE: begin
                dly_d = '0;
                if (vld_out && !soft_reset) begin
                    state_d = (START_DLY == 0) ? HDR_REQ : WAIT;
                end
            end
            WAIT: begin
                if (soft_reset || !vld_out) begin
                    state_d = IDLE;
                    dly_d   = '0;
                end else if (dly_q == DLY_LAST) begin
                    state_d = HDR_REQ;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + 5'd1;
                end
            end
            HDR_REQ: begin
                read_enb = vld_out && !rd_stall;
                if (soft_reset) begin
                    state_d   = IDLE;
                    pkt_abort = 1'b1;
                end else if (read_enb) begin
                    state_d = HDR_CAP;
                end
            end
            HDR_CAP: begin
                if (soft_reset) begin
                    state_d   = IDLE;
                    pkt_abort = 1'b1;
                end else begin
                    pkt_len_d  = data_out[7:2];
                    acc_d      = data_out;
                    req_left_d = {1'b0, data_out[7:2]} + 7'd1;
                    cap_left_d = {1'b0, data_out[7:2]} + 7'd1;
                    state_d    = BODY;
                end
            end
            BODY: begin
                read_enb = (req_left_q != '0) && vld_out && !rd_stall;
                if (soft_reset) begin
                    // rd_d stays 0, so any read already in flight is dropped
                    state_d   = IDLE;
                    pkt_abort = 1'b1;
                end else begin
                    rd_d = read_enb;
                    if (read_enb) begin
                        req_left_d = req_left_q - 7'd1;
                    end
                    if (rd_q) begin
                        cap_left_d = cap_left_q - 7'd1;
                        if (cap_left_q > 7'd1) begin
                            acc_d = acc_q ^ data_out;
                        end else begin
                            pkt_err_d = (acc_q != data_out);
                            state_d   = DONE;
                        end
                    end
                end
            end
            DONE: begin
                pkt_done = 1'b1;
                if (pkt_err_q) begin
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                end else begin
                    if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign pkt_err = pkt_err_q;
    assign pkt_len = pkt_len_q;
    assign pkt_cnt = pkt_cnt_q;
    assign err_cnt = err_cnt_q;

endmodule
